// File: rtl/bank_cmd_queues.sv
// bank_cmd_queues: per-bank command FIFOs between the request translator and
// the command scheduler. One request per cycle is routed by its channel/rank/
// bank-group/bank address into one of NUM_BNK_TOT FIFOs. Each FIFO's front
// packet is presented with a valid flag, and the scheduler pops FIFOs through
// a dequeue vector.
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_valid/o_req_ready request handshake; i_req_* request packet fields
//   o_cmd..o_data_ptr       per-bank front packet (zero when bank empty)
//   o_valid                 per-bank non-empty flags
//   i_dequeue               per-bank pop requests
//   o_addr_err, o_deq_err   registered one-cycle error pulses
module bank_cmd_queues #(
  parameter int unsigned CMD_TYPE_WIDTH = 3,
  parameter int unsigned NUM_CH         = 1,
  parameter int unsigned NUM_RNK        = 1,
  parameter int unsigned NUM_BG         = 2,
  parameter int unsigned NUM_BNK        = 4,
  parameter int unsigned CH_SEL_WIDTH   = 1,
  parameter int unsigned RNK_SEL_WIDTH  = 1,
  parameter int unsigned BG_SEL_WIDTH   = 1,
  parameter int unsigned BNK_SEL_WIDTH  = 2,
  parameter int unsigned ROW_SEL_WIDTH  = 16,
  parameter int unsigned COL_SEL_WIDTH  = 10,
  parameter int unsigned DATA_PTR_WIDTH = 5,
  parameter int unsigned QUEUE_DEPTH    = 4,
  localparam int unsigned NUM_BNK_TOT   = NUM_CH * NUM_RNK * NUM_BG * NUM_BNK
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic                                          i_req_valid,
  output logic                                          o_req_ready,
  input  logic [CMD_TYPE_WIDTH-1:0]                     i_req_cmd,
  input  logic [CH_SEL_WIDTH-1:0]                       i_req_channel,
  input  logic [RNK_SEL_WIDTH-1:0]                      i_req_rank,
  input  logic [BG_SEL_WIDTH-1:0]                       i_req_bgroup,
  input  logic [BNK_SEL_WIDTH-1:0]                      i_req_bank,
  input  logic [ROW_SEL_WIDTH-1:0]                      i_req_row,
  input  logic [COL_SEL_WIDTH-1:0]                      i_req_column,
  input  logic [DATA_PTR_WIDTH-1:0]                     i_req_data_ptr,
  output logic [NUM_BNK_TOT-1:0][CMD_TYPE_WIDTH-1:0]    o_cmd,
  output logic [NUM_BNK_TOT-1:0][CH_SEL_WIDTH-1:0]      o_channel,
  output logic [NUM_BNK_TOT-1:0][RNK_SEL_WIDTH-1:0]     o_rank,
  output logic [NUM_BNK_TOT-1:0][BG_SEL_WIDTH-1:0]      o_bgroup,
  output logic [NUM_BNK_TOT-1:0][BNK_SEL_WIDTH-1:0]     o_bank,
  output logic [NUM_BNK_TOT-1:0][ROW_SEL_WIDTH-1:0]     o_row,
  output logic [NUM_BNK_TOT-1:0][COL_SEL_WIDTH-1:0]     o_column,
  output logic [NUM_BNK_TOT-1:0][DATA_PTR_WIDTH-1:0]    o_data_ptr,
  output logic [NUM_BNK_TOT-1:0]                        o_valid,
  input  logic [NUM_BNK_TOT-1:0]                        i_dequeue,
  output logic                                          o_addr_err,
  output logic                                          o_deq_err
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = CMD_TYPE_WIDTH + CH_SEL_WIDTH + RNK_SEL_WIDTH +
                                  BG_SEL_WIDTH + BNK_SEL_WIDTH + ROW_SEL_WIDTH +
                                  COL_SEL_WIDTH + DATA_PTR_WIDTH;

  logic [ENT_W-1:0] mem    [NUM_BNK_TOT][QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr [NUM_BNK_TOT];
  logic [PTR_W-1:0] rd_ptr [NUM_BNK_TOT];
  logic [CNT_W-1:0] cnt    [NUM_BNK_TOT];

  logic                   addr_oor;
  int unsigned            idx_full;
  logic [NUM_BNK_TOT-1:0] hit;
  logic [NUM_BNK_TOT-1:0] full_vec;
  logic [NUM_BNK_TOT-1:0] push_vec;
  logic [NUM_BNK_TOT-1:0] pop_vec;
  logic [ENT_W-1:0]       req_ent;
  logic                   addr_err_nxt;
  logic                   deq_err_nxt;

  assign req_ent = {i_req_cmd, i_req_channel, i_req_rank, i_req_bgroup,
                    i_req_bank, i_req_row, i_req_column, i_req_data_ptr};

  // Address decode, handshake and per-bank push/pop decisions.
  // Ready never looks at i_dequeue: a full bank refuses even while being popped.
  always_comb begin
    addr_oor     = 1'b0;
    idx_full     = 0;
    hit          = '0;
    full_vec     = '0;
    push_vec     = '0;
    pop_vec      = '0;
    o_req_ready  = 1'b0;
    addr_err_nxt = 1'b0;
    deq_err_nxt  = 1'b0;

    addr_oor = (32'(i_req_channel) >= NUM_CH)  || (32'(i_req_rank) >= NUM_RNK) ||
               (32'(i_req_bgroup)  >= NUM_BG)  || (32'(i_req_bank) >= NUM_BNK);
    idx_full = ((32'(i_req_channel) * NUM_RNK + 32'(i_req_rank)) * NUM_BG +
                32'(i_req_bgroup)) * NUM_BNK + 32'(i_req_bank);

    for (int i = 0; i < int'(NUM_BNK_TOT); i++) begin
      hit[i]      = !addr_oor && (idx_full == 32'(i));
      full_vec[i] = (cnt[i] == CNT_W'(QUEUE_DEPTH));
      pop_vec[i]  = i_dequeue[i] && (cnt[i] != '0);
    end

    o_req_ready  = !i_rst && (addr_oor || !(|(hit & full_vec)));
    push_vec     = (i_req_valid && o_req_ready) ? hit : '0;
    addr_err_nxt = i_req_valid && o_req_ready && addr_oor;
    deq_err_nxt  = |(i_dequeue & ~pop_vec);
  end

  // FIFO storage, pointers and counts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NUM_BNK_TOT); i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
        for (int j = 0; j < int'(QUEUE_DEPTH); j++) mem[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_BNK_TOT); i++) begin
        if (push_vec[i]) begin
          mem[i][wr_ptr[i]] <= req_ent;
          wr_ptr[i]         <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop_vec[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push_vec[i] && !pop_vec[i])      cnt[i] <= cnt[i] + CNT_W'(1);
        else if (!push_vec[i] && pop_vec[i]) cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  // Error pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_addr_err <= 1'b0;
      o_deq_err  <= 1'b0;
    end else begin
      o_addr_err <= addr_err_nxt;
      o_deq_err  <= deq_err_nxt;
    end
  end

  // Front packet per bank, forced to zero when the bank is empty.
  always_comb begin
    o_valid    = '0;
    o_cmd      = '0;
    o_channel  = '0;
    o_rank     = '0;
    o_bgroup   = '0;
    o_bank     = '0;
    o_row      = '0;
    o_column   = '0;
    o_data_ptr = '0;
    for (int i = 0; i < int'(NUM_BNK_TOT); i++) begin
      o_valid[i] = (cnt[i] != '0);
      if (o_valid[i]) begin
        {o_cmd[i], o_channel[i], o_rank[i], o_bgroup[i], o_bank[i],
         o_row[i], o_column[i], o_data_ptr[i]} = mem[i][rd_ptr[i]];
      end
    end
  end

endmodule

// File: tb/tb_bank_cmd_queues.sv
// Randomized and directed bench for bank_cmd_queues, checked against a
// queue-based reference model. Bank-group field widened to 2 bits so that
// out-of-range bank groups can be exercised.
module tb_bank_cmd_queues;
  localparam int NB = 8;
  localparam int QD = 4;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_req_valid;
  logic o_req_ready;
  logic [2:0]  i_req_cmd;
  logic [0:0]  i_req_channel;
  logic [0:0]  i_req_rank;
  logic [1:0]  i_req_bgroup;
  logic [1:0]  i_req_bank;
  logic [15:0] i_req_row;
  logic [9:0]  i_req_column;
  logic [4:0]  i_req_data_ptr;
  logic [NB-1:0][2:0]  o_cmd;
  logic [NB-1:0][0:0]  o_channel;
  logic [NB-1:0][0:0]  o_rank;
  logic [NB-1:0][1:0]  o_bgroup;
  logic [NB-1:0][1:0]  o_bank;
  logic [NB-1:0][15:0] o_row;
  logic [NB-1:0][9:0]  o_column;
  logic [NB-1:0][4:0]  o_data_ptr;
  logic [NB-1:0] o_valid;
  logic [NB-1:0] i_dequeue;
  logic o_addr_err;
  logic o_deq_err;

  always #5 i_clk = ~i_clk;

  bank_cmd_queues #(.BG_SEL_WIDTH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_cmd(i_req_cmd), .i_req_channel(i_req_channel), .i_req_rank(i_req_rank),
    .i_req_bgroup(i_req_bgroup), .i_req_bank(i_req_bank), .i_req_row(i_req_row),
    .i_req_column(i_req_column), .i_req_data_ptr(i_req_data_ptr),
    .o_cmd(o_cmd), .o_channel(o_channel), .o_rank(o_rank), .o_bgroup(o_bgroup),
    .o_bank(o_bank), .o_row(o_row), .o_column(o_column), .o_data_ptr(o_data_ptr),
    .o_valid(o_valid), .i_dequeue(i_dequeue),
    .o_addr_err(o_addr_err), .o_deq_err(o_deq_err)
  );

  int checks = 0;
  int failures = 0;
  logic [39:0] model_q [NB][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mk(input int cmd, input int ch, input int rk,
                                     input int bg, input int bk, input int dp);
    logic [15:0] row = 16'($urandom);
    logic [9:0]  col = 10'($urandom);
    return {3'(cmd), 1'(ch), 1'(rk), 2'(bg), 2'(bk), row, col, 5'(dp)};
  endfunction

  function automatic logic [39:0] front_of(input int i);
    return {o_cmd[i], o_channel[i], o_rank[i], o_bgroup[i], o_bank[i],
            o_row[i], o_column[i], o_data_ptr[i]};
  endfunction

  // Compare every bank's front/valid against the model, plus error pulses.
  task automatic check_outputs(input logic exp_aerr, input logic exp_derr);
    logic [NB-1:0] ev;
    for (int i = 0; i < NB; i++) begin
      ev[i] = (model_q[i].size() != 0);
      check($sformatf("front%0d", i), 64'(front_of(i)),
            ev[i] ? 64'(model_q[i][0]) : 64'd0);
    end
    check("valid", 64'(o_valid), 64'(ev));
    check("addr_err", 64'(o_addr_err), 64'(exp_aerr));
    check("deq_err", 64'(o_deq_err), 64'(exp_derr));
  endtask

  // One clock cycle: drive after negedge, predict, update model at posedge.
  task automatic cycle(input logic v, input logic [39:0] ent, input logic [NB-1:0] deq);
    logic oor, exp_rdy, exp_aerr, exp_derr, push;
    int t;
    i_req_valid = v;
    {i_req_cmd, i_req_channel, i_req_rank, i_req_bgroup, i_req_bank,
     i_req_row, i_req_column, i_req_data_ptr} = ent;
    i_dequeue = deq;
    #1;
    oor = (i_req_channel != 0) || (i_req_rank != 0) || (i_req_bgroup >= 2);
    t = int'(i_req_bgroup) * 4 + int'(i_req_bank);
    exp_rdy = oor ? 1'b1 : (model_q[t].size() != QD);
    check("req_ready", 64'(o_req_ready), 64'(exp_rdy));
    push = v && exp_rdy && !oor;
    exp_aerr = v && exp_rdy && oor;
    exp_derr = 1'b0;
    @(posedge i_clk);
    for (int i = 0; i < NB; i++) begin
      if (deq[i]) begin
        if (model_q[i].size() != 0) void'(model_q[i].pop_front());
        else exp_derr = 1'b1;
      end
    end
    if (push) model_q[t].push_back(ent);
    @(negedge i_clk);
    check_outputs(exp_aerr, exp_derr);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) model_q[i].delete();
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic async_reset();
    i_req_valid = 1'b1;
    {i_req_cmd, i_req_channel, i_req_rank, i_req_bgroup, i_req_bank,
     i_req_row, i_req_column, i_req_data_ptr} = mk(1, 0, 0, 0, 1, 0);
    i_dequeue = '0;
    #2 i_rst = 1'b1;
    #1;
    clear_model();
    check("rst_ready", 64'(o_req_ready), 64'd0);
    check_outputs(1'b0, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    logic [39:0] e;
    logic [NB-1:0] d;
    int ch, bg;

    i_rst = 1'b1;
    i_req_valid = 1'b0;
    i_dequeue = '0;
    {i_req_cmd, i_req_channel, i_req_rank, i_req_bgroup, i_req_bank,
     i_req_row, i_req_column, i_req_data_ptr} = '0;
    #1;
    check("rst_ready_init", 64'(o_req_ready), 64'd0);
    check_outputs(1'b0, 1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // ACT to bg1/bk2 lands in bank 6.
    e = mk(3'd1, 0, 0, 1, 2, 7);
    cycle(1'b1, e, '0);
    check("act_valid", 64'(o_valid), 64'h40);
    check("act_cmd", 64'(o_cmd[6]), 64'd1);
    check("act_front", 64'(front_of(6)), 64'(e));
    cycle(1'b0, '0, 8'h40);

    // Fill bank 0, confirm backpressure only on bank 0, drain in order.
    for (int k = 0; k < 4; k++) cycle(1'b1, mk(2, 0, 0, 0, 0, k), '0);
    cycle(1'b1, mk(2, 0, 0, 0, 0, 9), '0);
    cycle(1'b1, mk(2, 0, 0, 0, 1, 9), '0);
    for (int k = 0; k < 4; k++) begin
      check("drain_dp", 64'(o_data_ptr[0]), 64'(k));
      cycle(1'b0, '0, 8'h01);
    end
    check("drain_empty", 64'(o_valid[0]), 64'd0);
    cycle(1'b0, '0, 8'h02);

    // Bank 0 at depth 2, simultaneous push/pop for 6 cycles.
    cycle(1'b1, mk(3, 0, 0, 0, 0, 20), '0);
    cycle(1'b1, mk(3, 0, 0, 0, 0, 21), '0);
    for (int k = 0; k < 6; k++) begin
      check("stream_dp", 64'(o_data_ptr[0]), 64'(20 + k));
      cycle(1'b1, mk(3, 0, 0, 0, 0, 22 + k), 8'h01);
    end
    cycle(1'b0, '0, 8'h01);
    cycle(1'b0, '0, 8'h01);

    // Bank 3 full: push refused while popped in the same cycle.
    for (int k = 0; k < 4; k++) cycle(1'b1, mk(4, 0, 0, 0, 3, k), '0);
    cycle(1'b1, mk(4, 0, 0, 0, 3, 30), 8'h08);
    check("full_pop_sz", 64'(model_q[3].size()), 64'd3);
    check("full_pop_dp", 64'(o_data_ptr[3]), 64'd1);

    // Out-of-range bank group and channel; dequeue of empty bank 5.
    cycle(1'b1, mk(5, 0, 0, 3, 1, 0), '0);
    check("bg_oor_err", 64'(o_addr_err), 64'd1);
    cycle(1'b1, mk(5, 1, 0, 0, 1, 0), 8'h20);
    check("deq_empty_err", 64'(o_deq_err), 64'd1);
    cycle(1'b0, '0, '0);
    check("err_clear", 64'({o_addr_err, o_deq_err}), 64'd0);

    // Reset with several banks non-empty.
    cycle(1'b1, mk(6, 0, 0, 1, 0, 1), '0);
    cycle(1'b1, mk(6, 0, 0, 1, 1, 2), '0);
    check("pre_rst_valid", 64'(o_valid), 64'h38);
    async_reset();
    cycle(1'b1, mk(1, 0, 0, 0, 0, 3), '0);

    // Randomized traffic with a reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      ch = ($urandom_range(0, 15) == 0) ? 1 : 0;
      bg = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 1));
      e = mk($urandom_range(0, 7), ch, ($urandom_range(0, 31) == 0) ? 1 : 0,
             bg, $urandom_range(0, 3), $urandom_range(0, 31));
      d = NB'($urandom) & NB'($urandom);
      if (n % 500 < 250) d = d & NB'($urandom);
      cycle($urandom_range(0, 3) != 0, e, d);
      if (n == 1500) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
